uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among four requesters (board renderer, status reporter, debug echo, spare).
- Each requester sends a multi-byte packet over a per-byte valid/ready handshake.
- Arbitration is round-robin at packet granularity; a granted requester keeps the transmitter until its last byte is sent.
- A stall watchdog reclaims the transmitter from a requester that stops supplying bytes mid-packet.

---
 rtl/uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter among four requesters.
// Latency: valid in IDLE at t -> grant t+1 -> send t+2; one byte in flight until the txdone rising edge.
// Backpressure: req_ready only for the owner in SEND; an owner stalled for TIMEOUT SEND cycles is revoked.
module uart_tx_arbiter #(
    parameter int TIMEOUT = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_id,
    output logic        send,
    output logic [7:0]  txdata,
    input  logic        txdone
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [1:0]  ptr, ptr_nx;
    logic [1:0]  owner, owner_nx;
    logic [1:0]  err_id_nx;
    logic [15:0] cnt, cnt_nx;
    logic        last_q, last_nx;
    logic        err_nx, send_nx;
    logic [7:0]  txdata_nx;
    logic        txdone_q;
    logic        done_edge;
    logic        owner_vld;
    logic [1:0]  pick;
    logic        pick_vld;

    // Works for both a one-cycle pulse and a level that drops after send.
    assign done_edge = txdone & ~txdone_q;
    assign owner_vld = req_valid[owner];

    assign busy      = (state != IDLE);
    assign grant     = busy ? (4'b0001 << owner) : 4'b0000;
    assign req_ready = (state == SEND && owner_vld) ? (4'b0001 << owner) : 4'b0000;

    // First valid requester at or after ptr; the descending loop lets the nearest one win.
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[ptr + 2'(k)]) begin
                pick     = ptr + 2'(k);
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        owner_nx  = owner;
        cnt_nx    = cnt;
        last_nx   = last_q;
        err_nx    = 1'b0;
        err_id_nx = err_id;
        send_nx   = 1'b0;
        txdata_nx = txdata;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    owner_nx = pick;
                    cnt_nx   = '0;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (owner_vld) begin
                    txdata_nx = req_data[{owner, 3'b000} +: 8];
                    last_nx   = req_last[owner];
                    send_nx   = 1'b1;
                    cnt_nx    = '0;
                    state_nx  = WAIT;
                end else if (cnt == CNT_MAX) begin
                    err_nx    = 1'b1;
                    err_id_nx = owner;
                    ptr_nx    = owner + 2'd1;
                    cnt_nx    = '0;
                    state_nx  = IDLE;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            WAIT: begin
                if (done_edge) begin
                    if (last_q) begin
                        ptr_nx   = owner + 2'd1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = SEND;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            owner    <= 2'd0;
            cnt      <= 16'd0;
            last_q   <= 1'b0;
            err      <= 1'b0;
            err_id   <= 2'd0;
            send     <= 1'b0;
            txdata   <= 8'd0;
            txdone_q <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            owner    <= owner_nx;
            cnt      <= cnt_nx;
            last_q   <= last_nx;
            err      <= err_nx;
            err_id   <= err_id_nx;
            send     <= send_nx;
            txdata   <= txdata_nx;
            txdone_q <= txdone;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester/UART models, arbitration vector table,
// directed corner sequences and randomized packets against a queue-based round-robin model.
module tb_uart_tx_arbiter;
    localparam int TO = 8;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        err;
    logic [1:0]  err_id;
    logic        send;
    logic [7:0]  txdata;
    logic        txdone;

    uart_tx_arbiter #(.TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .busy      (busy),
        .err       (err),
        .err_id    (err_id),
        .send      (send),
        .txdata    (txdata),
        .txdone    (txdone)
    );

    typedef struct { logic [7:0] d; bit last; } item_t;
    typedef struct { int prev; logic [3:0] mask; logic [3:0] exp_grant; } arb_vec_t;

    item_t      rq[4][$];
    item_t      mq[4][$];
    logic [9:0] sent_q[$];
    logic [9:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0, viol = 0, err_cnt = 0, err_cyc = 0, done_cyc = 0;
    int         rdy_cnt[4];
    int         gap[4];
    logic [1:0] err_id_s = '0;
    logic [3:0] err_grant = '0, grant_or = '0, acc = '0;
    logic       txdone_n = 1'b0;
    bit         gap_en = 1'b0, urand_dly = 1'b0, uart_level = 1'b0, ubusy = 1'b0;
    int         uart_delay = 20, ucnt = 0, udly = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Requester model: one byte presented per requester, popped when accepted.
    initial begin
        item_t it;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clock); #1;
            for (int i = 0; i < 4; i++) begin
                if (reset) begin
                    gap[i]       = 0;
                    req_valid[i] = 1'b0;
                end else begin
                    if (acc[i] && rq[i].size() > 0) begin
                        it = rq[i].pop_front();
                        if (!it.last && gap_en) gap[i] = $urandom_range(0, 4);
                    end
                    if (gap[i] > 0) begin
                        req_valid[i] = 1'b0;
                        gap[i]--;
                    end else begin
                        req_valid[i] = (rq[i].size() > 0);
                    end
                    if (rq[i].size() > 0) begin
                        it = rq[i][0];
                        req_data[8*i +: 8] = it.d;
                        req_last[i]        = it.last;
                    end
                end
            end
        end
    end

    // UART model: completion after a delay, as a pulse or as a level that dips after send.
    initial begin
        txdone = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (reset) begin
                ubusy  = 1'b0;
                txdone = uart_level;
            end else begin
                if (!uart_level) txdone = 1'b0;
                if (send) begin
                    ubusy = 1'b1;
                    ucnt  = 0;
                    udly  = urand_dly ? $urandom_range(3, 6) : uart_delay;
                end else if (ubusy) begin
                    ucnt++;
                    if (uart_level && ucnt == 2) txdone = 1'b0;
                    if (ucnt == udly) begin
                        ubusy  = 1'b0;
                        txdone = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: logs sent bytes with owner, ready pulses, invariant violations and err events.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            acc = reset ? 4'b0 : req_ready;
            if (!reset) begin
                if (send) sent_q.push_back({oh2idx(grant), txdata});
                for (int i = 0; i < 4; i++) if (req_ready[i]) rdy_cnt[i]++;
                grant_or = grant_or | grant;
                if ($countones(req_ready) > 1 || $countones(grant) > 1 ||
                    (req_ready & ~grant) != 4'b0 || busy != (grant != 4'b0)) viol++;
                if (err) begin
                    err_cnt++;
                    err_cyc   = cyc;
                    err_id_s  = err_id;
                    err_grant = grant;
                end
                if (txdone && !txdone_n && busy) done_cyc = cyc;
            end
            txdone_n = txdone;
        end
    end

    task automatic tick();
        @(negedge clock); #1;
    endtask

    function automatic bit pending();
        return (rq[0].size() + rq[1].size() + rq[2].size() + rq[3].size()) > 0;
    endfunction

    task automatic clear_log();
        sent_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
        grant_or = '0;
        viol     = 0;
        err_cnt  = 0;
    endtask

    task automatic do_reset();
        tick(); #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) rq[i].delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push_pkt(input int r, input int len, input logic [7:0] base, input bit rnd);
        item_t it;
        for (int k = 0; k < len; k++) begin
            it.d    = rnd ? 8'($urandom) : base + 8'(k);
            it.last = (k == len - 1);
            rq[r].push_back(it);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        tick(); tick();
        while ((busy || pending()) && n < budget) begin
            tick();
            n++;
        end
        check({name, "_drain"}, {30'd0, busy, pending()}, 32'd0);
    endtask

    task automatic wait_grant(output logic [3:0] g);
        int n;
        n = 0;
        while (grant == 4'b0 && n < 50) begin
            tick();
            n++;
        end
        g = grant;
    endtask

    // Reference: whole packets in round-robin order over requesters holding pending packets.
    task automatic build_expect(input int start, output int fin);
        item_t it;
        int p, pick;
        for (int i = 0; i < 4; i++) mq[i] = rq[i];
        exp_q.delete();
        p    = start;
        pick = 0;
        while (pick >= 0) begin
            pick = -1;
            for (int k = 0; k < 4; k++)
                if (pick < 0 && mq[(p + k) % 4].size() > 0) pick = (p + k) % 4;
            if (pick >= 0) begin
                do begin
                    it = mq[pick].pop_front();
                    exp_q.push_back({2'(pick), it.d});
                end while (!it.last && mq[pick].size() > 0);
                p = (pick + 1) % 4;
            end
        end
        fin = p;
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, sent_q.size(), exp_q.size());
        for (int k = 0; k < sent_q.size() && k < exp_q.size(); k++)
            check($sformatf("%s_b%0d", name, k), {22'd0, sent_q[k]}, {22'd0, exp_q[k]});
        check({name, "_inv"}, viol, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, got time %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        arb_vec_t   vecs[10];
        logic [3:0] g;
        int         rot[8];
        int         n, mptr, nptr;
        item_t      it;

        vecs[0] = '{-1, 4'b0101, 4'b0001};
        vecs[1] = '{ 0, 4'b0001, 4'b0001};
        vecs[2] = '{ 0, 4'b0011, 4'b0010};
        vecs[3] = '{ 1, 4'b0011, 4'b0001};
        vecs[4] = '{ 2, 4'b1111, 4'b1000};
        vecs[5] = '{ 3, 4'b1111, 4'b0001};
        vecs[6] = '{ 3, 4'b0100, 4'b0100};
        vecs[7] = '{ 1, 4'b1001, 4'b1000};
        vecs[8] = '{ 2, 4'b0110, 4'b0010};
        vecs[9] = '{-1, 4'b1100, 4'b0100};
        rot = '{0, 1, 2, 3, 0, 1, 2, 3};

        reset = 1'b1;
        repeat (3) tick();
        check("rst_grant", grant, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_send", send, 0);
        check("rst_txdata", txdata, 0);
        check("rst_err", err, 0);
        check("rst_err_id", err_id, 0);
        reset = 1'b0;
        tick();

        // Single requester, three bytes, completion 20 cycles after each send.
        clear_log();
        uart_delay = 20;
        push_pkt(1, 3, 8'h41, 1'b0);
        wait_idle("t1", 500);
        exp_q = '{10'h141, 10'h142, 10'h143};
        compare_stream("t1");
        check("t1_ready1", rdy_cnt[1], 3);
        check("t1_grant_or", grant_or, 4'b0010);
        push_pkt(1, 1, 8'h51, 1'b0);
        push_pkt(2, 1, 8'h52, 1'b0);
        wait_grant(g);
        check("t1_ptr2", g, 4'b0100);
        wait_idle("t1b", 200);

        uart_delay = 4;
        for (int v = 0; v < 10; v++) begin
            if (vecs[v].prev < 0) do_reset();
            else begin
                push_pkt(vecs[v].prev, 1, 8'hE0, 1'b0);
                wait_idle("arb_pre", 200);
            end
            for (int i = 0; i < 4; i++) if (vecs[v].mask[i]) push_pkt(i, 1, 8'h80 + 8'(i), 1'b0);
            wait_grant(g);
            check($sformatf("arb_vec%0d", v), g, vecs[v].exp_grant);
            wait_idle("arb", 400);
        end

        // Two simultaneous requesters from reset; also checks grant/send latency.
        do_reset();
        clear_log();
        push_pkt(0, 2, 8'hA0, 1'b0);
        push_pkt(2, 2, 8'hC0, 1'b0);
        build_expect(0, nptr);
        tick();
        check("t2_grant_t0", grant, 4'b0000);
        tick();
        check("t2_grant_t1", grant, 4'b0001);
        check("t2_ready_t1", req_ready, 4'b0001);
        tick();
        check("t2_send_t2", send, 1'b1);
        check("t2_txdata_t2", txdata, 8'hA0);
        wait_idle("t2", 400);
        compare_stream("t2");

        // All four requesting continuously with single-byte packets.
        do_reset();
        clear_log();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) push_pkt(i, 1, 8'(16 * i + r), 1'b0);
        wait_idle("t3", 600);
        check("t3_len", sent_q.size(), 8);
        for (int k = 0; k < sent_q.size() && k < 8; k++)
            check($sformatf("t3_owner%0d", k), {30'd0, sent_q[k][9:8]}, rot[k]);
        for (int i = 0; i < 4; i++) check($sformatf("t3_ready%0d", i), rdy_cnt[i], 2);
        check("t3_inv", viol, 0);

        // Level-style txdone: same byte sequence as the pulse case.
        uart_level = 1'b1;
        uart_delay = 20;
        do_reset();
        clear_log();
        push_pkt(1, 3, 8'h41, 1'b0);
        wait_idle("t4", 500);
        exp_q = '{10'h141, 10'h142, 10'h143};
        compare_stream("t4");
        uart_level = 1'b0;

        // Watchdog: requester 3 sends one non-last byte then stops.
        do_reset();
        clear_log();
        uart_delay = 5;
        it.d    = 8'h77;
        it.last = 1'b0;
        rq[3].push_back(it);
        wait_grant(g);
        check("t5_grant3", g, 4'b1000);
        push_pkt(0, 1, 8'h90, 1'b0);
        push_pkt(2, 1, 8'h92, 1'b0);
        n = 0;
        while (err_cnt == 0 && n < 200) begin
            tick();
            n++;
        end
        check("t5_err_seen", err_cnt, 1);
        check("t5_err_id", err_id_s, 3);
        check("t5_err_grant", err_grant, 0);
        check("t5_err_delay", err_cyc - done_cyc - 1, TO);
        tick();
        check("t5_err_pulse", err, 0);
        check("t5_regrant0", grant, 4'b0001);
        wait_idle("t5", 300);
        exp_q = '{10'h377, 10'h090, 10'h292};
        compare_stream("t5");
        check("t5_err_id_hold", err_id, 3);

        // Reset while waiting on byte 2 of 4.
        clear_log();
        uart_delay = 20;
        push_pkt(2, 4, 8'hB0, 1'b0);
        n = 0;
        while (sent_q.size() < 2 && n < 300) begin
            tick();
            n++;
        end
        check("t6_two_sent", sent_q.size(), 2);
        repeat (5) tick();
        #1;
        reset = 1'b1;
        #1;
        check("t6_grant", grant, 0);
        check("t6_ready", req_ready, 0);
        check("t6_busy", busy, 0);
        check("t6_send", send, 0);
        check("t6_txdata", txdata, 0);
        check("t6_err_id", err_id, 0);
        for (int i = 0; i < 4; i++) rq[i].delete();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        clear_log();
        push_pkt(1, 1, 8'h61, 1'b0);
        push_pkt(3, 1, 8'h63, 1'b0);
        wait_grant(g);
        check("t6_ptr0", g, 4'b0010);
        wait_idle("t6", 200);

        // Randomized packets, gaps and UART timing; ptr carries across rounds.
        do_reset();
        mptr      = 0;
        gap_en    = 1'b1;
        urand_dly = 1'b1;
        for (int rnd = 0; rnd < 6; rnd++) begin
            uart_level = 1'($urandom_range(0, 1));
            clear_log();
            for (int i = 0; i < 4; i++) begin
                n = $urandom_range(0, 2);
                for (int p = 0; p < n; p++) push_pkt(i, $urandom_range(1, 4), 8'h00, 1'b1);
            end
            build_expect(mptr, nptr);
            wait_idle($sformatf("rnd%0d", rnd), 3000);
            compare_stream($sformatf("rnd%0d", rnd));
            check($sformatf("rnd%0d_err", rnd), err_cnt, 0);
            mptr = nptr;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
